// File: rtl/ex_stage.sv
// Execute stage: ID/EX operand slot with write-back snooping and bypass, ALU,
// and an EX/WB result slot, with valid/ready on both sides and a flush kill.
module ex_stage #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        opcode,
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   input  logic [DATA_W-1:0] imm,
   input  logic              reg_write,
   input  logic [3:0]        alu_op,
   input  logic              flush,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_AW-1:0] out_rd,
   output logic [DATA_W-1:0] out_result,
   output logic              out_reg_write,
   output logic              out_zero,
   output logic              out_carry
);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;

   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_ANDI = 4'h9;
   localparam logic [3:0] OP_ORI  = 4'hA;
   localparam logic [3:0] OP_XORI = 4'hB;

   logic              a_valid_reg;
   logic [3:0]        a_opcode_reg;
   logic [3:0]        a_alu_op_reg;
   logic [REG_AW-1:0] a_rd_reg;
   logic [DATA_W-1:0] a_imm_reg;
   logic              a_reg_write_reg;

   logic              b_free;
   logic              a_adv;
   logic              accept;
   logic              xfer;

   assign b_free   = !out_valid || out_ready;
   assign a_adv    = a_valid_reg && b_free;
   assign in_ready = !a_valid_reg || b_free;
   assign accept   = in_valid && in_ready && !flush;
   // flush beats a pending A->B move; the offered instruction is also dropped
   assign xfer     = a_adv && !flush;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         logic [REG_AW-1:0] rs_in;
         logic [DATA_W-1:0] data_in;
         logic [REG_AW-1:0] rs_reg;
         logic [DATA_W-1:0] op_reg;
         logic [DATA_W-1:0] fwd_next;

         assign rs_in   = (gi == 0) ? rs1 : rs2;
         assign data_in = (gi == 0) ? rs1_data : rs2_data;

         // Youngest producer wins: EX/WB slot, then the write-back port, then the latch
         assign fwd_next = (out_valid && out_reg_write && out_rd == rs_reg) ? out_result :
                           (wb_we && wb_rd == rs_reg)                       ? wb_data    :
                                                                              op_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rs_reg <= '0;
               op_reg <= '0;
            end else if (accept) begin
               rs_reg <= rs_in;
               op_reg <= (wb_we && wb_rd == rs_in) ? wb_data : data_in;
            end else if (a_valid_reg && !a_adv && wb_we && wb_rd == rs_reg) begin
               op_reg <= wb_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid_reg     <= 1'b0;
         a_opcode_reg    <= '0;
         a_alu_op_reg    <= '0;
         a_rd_reg        <= '0;
         a_imm_reg       <= '0;
         a_reg_write_reg <= 1'b0;
      end else begin
         if (flush)
            a_valid_reg <= 1'b0;
         else if (accept)
            a_valid_reg <= 1'b1;
         else if (a_adv)
            a_valid_reg <= 1'b0;

         if (accept) begin
            a_opcode_reg    <= opcode;
            a_alu_op_reg    <= alu_op;
            a_rd_reg        <= rd;
            a_imm_reg       <= imm;
            a_reg_write_reg <= reg_write;
         end
      end
   end

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W:0]   sum_next;
   logic [DATA_W-1:0] result_next;
   logic              carry_next;

   assign op_a     = g_opnd[0].fwd_next;
   assign op_b     = (a_opcode_reg inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI}) ? a_imm_reg
                                                                               : g_opnd[1].fwd_next;
   assign sum_next = {1'b0, op_a} + {1'b0, op_b};

   always_comb begin
      result_next = '0;
      carry_next  = 1'b0;
      case (a_alu_op_reg)
         ALU_ADD: {carry_next, result_next} = sum_next;
         ALU_SUB: begin
            result_next = op_a - op_b;
            carry_next  = (op_a < op_b);
         end
         ALU_AND: result_next = op_a & op_b;
         ALU_OR:  result_next = op_a | op_b;
         ALU_XOR: result_next = op_a ^ op_b;
         ALU_SLT: result_next = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_rd        <= '0;
         out_result    <= '0;
         out_reg_write <= 1'b0;
         out_zero      <= 1'b0;
         out_carry     <= 1'b0;
      end else if (xfer) begin
         out_valid     <= 1'b1;
         out_rd        <= a_rd_reg;
         out_result    <= result_next;
         out_reg_write <= a_reg_write_reg;
         out_zero      <= (result_next == '0);
         out_carry     <= carry_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
